// File: rtl/i2c_master_sequencer.sv
// rtl/i2c_master_sequencer.sv - I2C master sequencer: SCL timing, one-hot phase strobes, transaction status
// prescaler must stay below 2**(CNT_W-1) so the full SCL period (2p) fits the edge counter.
module i2c_master_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             i2c_core_clock_i,
  input  logic             reset_bit_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] prescaler_i,
  input  logic [7:0]       addr_rw_i,
  input  logic [CNT_W-1:0] byte_count_i,
  input  logic             repeat_start_i,
  input  logic             sda_i,
  input  logic [CNT_W-1:0] counter_data_ack_i,
  output logic             scl_o,
  output logic             start_cnt_o,
  output logic             write_addr_cnt_o,
  output logic             write_data_cnt_o,
  output logic             read_data_cnt_o,
  output logic             write_ack_cnt_o,
  output logic             read_ack_cnt_o,
  output logic             stop_cnt_o,
  output logic             repeat_start_cnt_o,
  output logic [CNT_W-1:0] counter_detect_edge_o,
  output logic [CNT_W-1:0] counter_state_done_time_repeat_start_o,
  output logic [7:0]       addr_rw_o,
  output logic             ack_bit_o,
  output logic             data_req_o,
  output logic             rx_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             nack_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WRITE_ADDR, S_READ_ACK, S_WRITE_DATA,
    S_READ_DATA, S_WRITE_ACK, S_STOP, S_REPEAT_START
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] rs_cnt_q, rs_cnt_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       strobe_q, strobe_d;
  logic             repeat_q, repeat_d;
  logic             ack_after_data_q, ack_after_data_d;
  logic             stop_hold_q, stop_hold_d;
  logic             scl_q, scl_d;
  logic             ack_bit_q, ack_bit_d;
  logic             data_req_q, data_req_d;
  logic             rx_valid_q, rx_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;
  logic             go_end;

  logic [CNT_W-1:0] p_m1, p_m2, period_last, period_m2;
  logic [CNT_W-1:0] rem_after_write, rem_after_read;
  logic             period_end, byte_end;

  assign p_m1        = presc_q - CNT_W'(1);
  assign p_m2        = presc_q - CNT_W'(2);
  assign period_last = {presc_q[CNT_W-2:0], 1'b0} - CNT_W'(1);
  assign period_m2   = {presc_q[CNT_W-2:0], 1'b0} - CNT_W'(2);
  assign period_end  = (edge_q == period_last);
  assign byte_end    = period_end && (counter_data_ack_i == CNT_W'(2));

  // A write byte is only retired once its ACK comes back, so the address ACK must not decrement.
  assign rem_after_write = ack_after_data_q ? remaining_q - CNT_W'(1) : remaining_q;
  assign rem_after_read  = remaining_q - CNT_W'(1);

  always_comb begin
    state_d          = state_q;
    edge_d           = edge_q;
    presc_d          = presc_q;
    remaining_d      = remaining_q;
    rs_cnt_d         = rs_cnt_q;
    addr_d           = addr_q;
    repeat_d         = repeat_q;
    ack_after_data_d = ack_after_data_q;
    stop_hold_d      = stop_hold_q;
    ack_bit_d        = ack_bit_q;
    busy_d           = busy_q;
    nack_d           = nack_q;
    data_req_d       = 1'b0;
    rx_valid_d       = 1'b0;
    done_d           = 1'b0;
    go_end           = 1'b0;
    scl_d            = 1'b1;
    strobe_d         = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d          = S_START;
          edge_d           = '0;
          presc_d          = prescaler_i;
          addr_d           = addr_rw_i;
          remaining_d      = byte_count_i;
          repeat_d         = repeat_start_i;
          ack_after_data_d = 1'b0;
          nack_d           = 1'b0;
          busy_d           = 1'b1;
        end
      end
      S_START: begin
        if (edge_q == p_m1) begin
          state_d = S_WRITE_ADDR;
          edge_d  = '0;
        end else begin
          edge_d = edge_q + CNT_W'(1);
        end
      end
      S_WRITE_ADDR, S_WRITE_DATA, S_READ_DATA: begin
        edge_d = period_end ? '0 : edge_q + CNT_W'(1);
        if (byte_end) begin
          if (state_q == S_READ_DATA) begin
            state_d    = S_WRITE_ACK;
            rx_valid_d = 1'b1;
            ack_bit_d  = (remaining_q == CNT_W'(1));
          end else begin
            state_d          = S_READ_ACK;
            ack_after_data_d = (state_q == S_WRITE_DATA);
          end
        end
      end
      S_READ_ACK: begin
        edge_d = period_end ? '0 : edge_q + CNT_W'(1);
        if (period_end) begin
          if (sda_i) begin
            nack_d      = 1'b1;
            state_d     = S_STOP;
            stop_hold_d = 1'b0;
          end else begin
            remaining_d = rem_after_write;
            if (rem_after_write == '0) begin
              go_end = 1'b1;
            end else if (addr_q[0]) begin
              state_d = S_READ_DATA;
            end else begin
              state_d    = S_WRITE_DATA;
              data_req_d = 1'b1;
            end
          end
        end
      end
      S_WRITE_ACK: begin
        edge_d = period_end ? '0 : edge_q + CNT_W'(1);
        if (period_end) begin
          remaining_d = rem_after_read;
          if (rem_after_read == '0) begin
            go_end = 1'b1;
          end else begin
            state_d = S_READ_DATA;
          end
        end
      end
      S_STOP: begin
        // First a full SCL period for the data path to drive P, then p cycles of bus-free SCL high.
        if (!stop_hold_q) begin
          if (period_end) begin
            stop_hold_d = 1'b1;
            edge_d      = '0;
          end else begin
            edge_d = edge_q + CNT_W'(1);
          end
        end else if (edge_q == p_m1) begin
          state_d     = S_IDLE;
          edge_d      = '0;
          stop_hold_d = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end else begin
          edge_d = edge_q + CNT_W'(1);
        end
      end
      S_REPEAT_START: begin
        if (rs_cnt_q == '0) begin
          state_d = S_WRITE_ADDR;
          edge_d  = '0;
        end else begin
          rs_cnt_d = rs_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_end) begin
      edge_d = '0;
      if (repeat_q) begin
        state_d          = S_REPEAT_START;
        rs_cnt_d         = {presc_q[CNT_W-2:0], 1'b0};
        addr_d           = addr_rw_i;
        remaining_d      = byte_count_i;
        repeat_d         = repeat_start_i;
        ack_after_data_d = 1'b0;
      end else begin
        state_d     = S_STOP;
        stop_hold_d = 1'b0;
      end
    end

    // SCL and strobes are derived from next-state values so they line up with the registered counters.
    case (state_d)
      S_IDLE:         scl_d = 1'b1;
      S_START:        begin scl_d = 1'b1; strobe_d = 8'b0000_0001; end
      S_REPEAT_START: begin scl_d = !(rs_cnt_d > presc_q); strobe_d = 8'b1000_0000; end
      S_STOP: begin
        scl_d    = stop_hold_d || !((edge_d >= p_m2) && (edge_d <= period_m2));
        strobe_d = 8'b0100_0000;
      end
      default: begin
        scl_d = !((edge_d >= p_m2) && (edge_d <= period_m2));
        case (state_d)
          S_WRITE_ADDR: strobe_d = 8'b0000_0010;
          S_WRITE_DATA: strobe_d = 8'b0000_0100;
          S_READ_DATA:  strobe_d = 8'b0000_1000;
          S_WRITE_ACK:  strobe_d = 8'b0001_0000;
          S_READ_ACK:   strobe_d = 8'b0010_0000;
          default:      strobe_d = 8'b0000_0000;
        endcase
      end
    endcase
  end

  always_ff @(posedge i2c_core_clock_i or posedge reset_bit_i) begin
    if (reset_bit_i) begin
      state_q          <= S_IDLE;
      edge_q           <= '0;
      presc_q          <= '0;
      remaining_q      <= '0;
      rs_cnt_q         <= '0;
      addr_q           <= 8'd0;
      strobe_q         <= 8'd0;
      repeat_q         <= 1'b0;
      ack_after_data_q <= 1'b0;
      stop_hold_q      <= 1'b0;
      scl_q            <= 1'b1;
      ack_bit_q        <= 1'b0;
      data_req_q       <= 1'b0;
      rx_valid_q       <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      nack_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      edge_q           <= edge_d;
      presc_q          <= presc_d;
      remaining_q      <= remaining_d;
      rs_cnt_q         <= rs_cnt_d;
      addr_q           <= addr_d;
      strobe_q         <= strobe_d;
      repeat_q         <= repeat_d;
      ack_after_data_q <= ack_after_data_d;
      stop_hold_q      <= stop_hold_d;
      scl_q            <= scl_d;
      ack_bit_q        <= ack_bit_d;
      data_req_q       <= data_req_d;
      rx_valid_q       <= rx_valid_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      nack_q           <= nack_d;
    end
  end

  assign scl_o                                  = scl_q;
  assign start_cnt_o                            = strobe_q[0];
  assign write_addr_cnt_o                       = strobe_q[1];
  assign write_data_cnt_o                       = strobe_q[2];
  assign read_data_cnt_o                        = strobe_q[3];
  assign write_ack_cnt_o                        = strobe_q[4];
  assign read_ack_cnt_o                         = strobe_q[5];
  assign stop_cnt_o                             = strobe_q[6];
  assign repeat_start_cnt_o                     = strobe_q[7];
  assign counter_detect_edge_o                  = edge_q;
  assign counter_state_done_time_repeat_start_o = rs_cnt_q;
  assign addr_rw_o                              = addr_q;
  assign ack_bit_o                              = ack_bit_q;
  assign data_req_o                             = data_req_q;
  assign rx_valid_o                             = rx_valid_q;
  assign busy_o                                 = busy_q;
  assign done_o                                 = done_q;
  assign nack_o                                 = nack_q;

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// tb/tb_i2c_master_sequencer.sv - randomized bench for i2c_master_sequencer against a phase-timeline model
module tb_i2c_master_sequencer;

  localparam int PH_START = 0, PH_WA = 1, PH_WD = 2, PH_RD = 3, PH_WACK = 4, PH_RA = 5, PH_STOP = 6, PH_RS = 7;

  logic       clk = 1'b0;
  logic       reset_bit_i;
  logic       enable_i;
  logic [7:0] prescaler_i;
  logic [7:0] addr_rw_i;
  logic [7:0] byte_count_i;
  logic       repeat_start_i;
  logic       sda_i;
  logic [7:0] counter_data_ack_i;
  logic       scl_o, start_cnt_o, write_addr_cnt_o, write_data_cnt_o, read_data_cnt_o;
  logic       write_ack_cnt_o, read_ack_cnt_o, stop_cnt_o, repeat_start_cnt_o;
  logic [7:0] counter_detect_edge_o, counter_state_done_time_repeat_start_o, addr_rw_o;
  logic       ack_bit_o, data_req_o, rx_valid_o, busy_o, done_o, nack_o;
  logic [7:0] strobes;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         ph;
    int         len;
    logic       sda_end;
    int         ackb;
    logic       nk;
    logic [7:0] adr;
    bit         pre_rs;
  } seg_t;

  seg_t       segs[$];
  int         g_p;
  logic [7:0] cur_adr;
  logic       cur_nack;
  logic [7:0] g_a2;
  int         g_cnt2;

  always #5 clk = ~clk;

  assign strobes = {repeat_start_cnt_o, stop_cnt_o, read_ack_cnt_o, write_ack_cnt_o,
                    read_data_cnt_o, write_data_cnt_o, write_addr_cnt_o, start_cnt_o};

  i2c_master_sequencer #(.CNT_W(8)) dut (
    .i2c_core_clock_i(clk), .reset_bit_i(reset_bit_i), .enable_i(enable_i),
    .prescaler_i(prescaler_i), .addr_rw_i(addr_rw_i), .byte_count_i(byte_count_i),
    .repeat_start_i(repeat_start_i), .sda_i(sda_i), .counter_data_ack_i(counter_data_ack_i),
    .scl_o(scl_o), .start_cnt_o(start_cnt_o), .write_addr_cnt_o(write_addr_cnt_o),
    .write_data_cnt_o(write_data_cnt_o), .read_data_cnt_o(read_data_cnt_o),
    .write_ack_cnt_o(write_ack_cnt_o), .read_ack_cnt_o(read_ack_cnt_o), .stop_cnt_o(stop_cnt_o),
    .repeat_start_cnt_o(repeat_start_cnt_o), .counter_detect_edge_o(counter_detect_edge_o),
    .counter_state_done_time_repeat_start_o(counter_state_done_time_repeat_start_o),
    .addr_rw_o(addr_rw_o), .ack_bit_o(ack_bit_o), .data_req_o(data_req_o),
    .rx_valid_o(rx_valid_o), .busy_o(busy_o), .done_o(done_o), .nack_o(nack_o)
  );

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(int ph, int len, logic sda_end, int ackb);
    seg_t s;
    s.ph = ph; s.len = len; s.sda_end = sda_end; s.ackb = ackb;
    s.nk = cur_nack; s.adr = cur_adr; s.pre_rs = 1'b0;
    segs.push_back(s);
  endtask

  // One address phase plus its data bytes; ends in STOP, or in Sr when requested and no NACK occurred.
  task automatic build_part(logic [7:0] a, int cnt, int nk, bit rs_end, output bit did_rs);
    bit nacked = 0;
    did_rs = 0;
    cur_adr = a;
    push(PH_WA, 16 * g_p, 1'b0, 0);
    push(PH_RA, 2 * g_p, nk == 0, 0);
    if (nk == 0) nacked = 1;
    for (int k = 1; k <= cnt && !nacked; k++) begin
      if (!a[0]) begin
        push(PH_WD, 16 * g_p, 1'b0, 0);
        push(PH_RA, 2 * g_p, nk == k, 0);
        if (nk == k) nacked = 1;
      end else begin
        push(PH_RD, 16 * g_p, 1'b0, 0);
        push(PH_WACK, 2 * g_p, 1'b0, (k == cnt) ? 1 : 0);
      end
    end
    if (nacked) begin
      cur_nack = 1'b1;
      push(PH_STOP, 3 * g_p, 1'b0, 0);
    end else if (rs_end) begin
      segs[segs.size() - 1].pre_rs = 1'b1;
      cur_adr = g_a2;
      push(PH_RS, 2 * g_p + 1, 1'b0, 0);
      did_rs = 1;
    end else begin
      push(PH_STOP, 3 * g_p, 1'b0, 0);
    end
  endtask

  task automatic check_cycle(seg_t sg, int t);
    int p = g_p;
    int e = 0;
    int s = 1;
    int cd = 0;
    case (sg.ph)
      PH_START: begin e = t; s = 1; end
      PH_RS:    begin e = 0; cd = 2 * p - t; s = (cd > p) ? 0 : 1; end
      default: begin
        if (sg.ph == PH_STOP && t >= 2 * p) begin
          e = t - 2 * p; s = 1;
        end else begin
          e = t % (2 * p);
          s = (e >= p - 2 && e <= 2 * p - 2) ? 0 : 1;
        end
      end
    endcase
    chk("strobe", strobes, 1 << sg.ph);
    chk("scl", scl_o, s);
    chk("edge", counter_detect_edge_o, e);
    chk("rs_countdown", counter_state_done_time_repeat_start_o, cd);
    chk("busy", busy_o, 1);
    chk("done", done_o, 0);
    chk("nack", nack_o, sg.nk);
    chk("addr_rw", addr_rw_o, sg.adr);
    chk("data_req", data_req_o, (sg.ph == PH_WD && t == 0) ? 1 : 0);
    chk("rx_valid", rx_valid_o, (sg.ph == PH_WACK && t == 0) ? 1 : 0);
    if (sg.ph == PH_WACK) chk("ack_bit", ack_bit_o, sg.ackb);
  endtask

  // Plays the data path and a noisy host: junk on inputs the sequencer must ignore while busy.
  task automatic drive(seg_t sg, int t);
    enable_i           = 1'($urandom_range(0, 1));
    prescaler_i        = 8'($urandom);
    addr_rw_i          = 8'($urandom);
    byte_count_i       = 8'($urandom);
    repeat_start_i     = 1'($urandom_range(0, 1));
    sda_i              = 1'($urandom_range(0, 1));
    counter_data_ack_i = 8'($urandom_range(0, 9));
    if (sg.ph == PH_WA || sg.ph == PH_WD || sg.ph == PH_RD)
      counter_data_ack_i = 8'(9 - t / (2 * g_p));
    if (t == sg.len - 1) begin
      if (sg.ph == PH_RA) sda_i = sg.sda_end;
      if (sg.pre_rs) begin
        addr_rw_i      = g_a2;
        byte_count_i   = 8'(g_cnt2);
        repeat_start_i = 1'b0;
      end
    end
  endtask

  task automatic run(int p, logic [7:0] a, int cnt, bit rs, int nk,
                     logic [7:0] a2, int cnt2, int rst_at);
    int cyc = 0;
    bit did_rs;
    segs.delete();
    g_p = p; g_a2 = a2; g_cnt2 = cnt2;
    cur_nack = 1'b0; cur_adr = a;
    push(PH_START, p, 1'b0, 0);
    build_part(a, cnt, nk, rs, did_rs);
    if (did_rs) build_part(a2, cnt2, -1, 0, did_rs);

    enable_i = 1'b1; prescaler_i = 8'(p); addr_rw_i = a;
    byte_count_i = 8'(cnt); repeat_start_i = rs;
    foreach (segs[i]) begin
      for (int t = 0; t < segs[i].len; t++) begin
        @(negedge clk);
        check_cycle(segs[i], t);
        if (cyc == rst_at) begin
          reset_bit_i = 1'b1;
          #1;
          chk("rst_scl", scl_o, 1);
          chk("rst_strobe", strobes, 0);
          chk("rst_busy", busy_o, 0);
          chk("rst_edge", counter_detect_edge_o, 0);
          chk("rst_addr", addr_rw_o, 0);
          chk("rst_ack_bit", ack_bit_o, 0);
          @(negedge clk);
          reset_bit_i = 1'b0;
          enable_i = 1'b0;
          return;
        end
        drive(segs[i], t);
        cyc++;
      end
    end
    @(negedge clk);
    chk("end_done", done_o, 1);
    chk("end_busy", busy_o, 0);
    chk("end_strobe", strobes, 0);
    chk("end_scl", scl_o, 1);
    chk("end_nack", nack_o, cur_nack);
    enable_i = 1'b0;
    @(negedge clk);
    chk("idle_done", done_o, 0);
    chk("idle_strobe", strobes, 0);
  endtask

  initial begin
    reset_bit_i = 1'b1; enable_i = 1'b0; prescaler_i = 8'd0; addr_rw_i = 8'd0;
    byte_count_i = 8'd0; repeat_start_i = 1'b0; sda_i = 1'b0; counter_data_ack_i = 8'd9;
    repeat (3) @(negedge clk);
    chk("reset_scl", scl_o, 1);
    chk("reset_strobe", strobes, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_nack", nack_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_addr", addr_rw_o, 0);
    reset_bit_i = 1'b0;
    @(negedge clk);

    run(4, 8'hA0, 1, 0, -1, 8'h00, 0, -1);
    run(4, 8'hA1, 2, 0, -1, 8'h00, 0, -1);
    run(4, 8'h42, 2, 1, 0, 8'h00, 0, -1);
    run(4, 8'h42, 0, 1, -1, 8'h43, 1, -1);
    run(4, 8'hA1, 2, 0, -1, 8'h00, 0, 76 + int'($urandom_range(0, 63)));
    run(4, 8'hA0, 1, 0, -1, 8'h00, 0, -1);
    run(5, 8'h3C, 3, 0, 2, 8'h00, 0, -1);

    for (int n = 0; n < 12; n++) begin
      int p   = int'($urandom_range(3, 7));
      int cnt = int'($urandom_range(0, 3));
      int nk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cnt)) : -1;
      run(p, 8'($urandom), cnt, 1'($urandom_range(0, 1)), nk,
          8'($urandom), int'($urandom_range(0, 2)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_sequencer.md
Name: i2c_master_sequencer

Overview:
- Master-side controller that sequences the I2C data path block through one transaction: START, address+R/W, ACK, N data bytes, STOP or repeated START.
- Generates SCL, the per-bit-period edge counter, and one-hot phase strobes (start/write_addr/write_data/read_data/write_ack/read_ack/stop/repeat_start) consumed by the data path.
- Tracks the data path's bit/ack counter and reports status (busy, done, NACK) to the host register block.

Parameters:
- CNT_W, 8, width of prescaler, edge counter and byte counter.

Ports:
- i2c_core_clock_i  in  1  core clock; the only clock.
- reset_bit_i  in  1  reset; asynchronous, active-high.
- enable_i  in  1  host command strobe, sampled in IDLE.
- prescaler_i  in  CNT_W  half SCL period in core clocks; legal ≥3.
- addr_rw_i  in  8  slave address[7:1], R/W[0] (1=read).
- byte_count_i  in  CNT_W  data bytes to transfer; 0 = address only.
- repeat_start_i  in  1  end with Sr instead of P.
- sda_i  in  1  bus SDA sample.
- counter_data_ack_i  in  CNT_W  bit/ack counter from data path (9..1, 0 transient).
- scl_o  out  1  SCL drive.
- start_cnt_o, write_addr_cnt_o, write_data_cnt_o, read_data_cnt_o, write_ack_cnt_o, read_ack_cnt_o, stop_cnt_o, repeat_start_cnt_o  out  1 each  one-hot phase strobes.
- counter_detect_edge_o  out  CNT_W  position within the SCL period.
- counter_state_done_time_repeat_start_o  out  CNT_W  Sr countdown.
- addr_rw_o  out  8  latched address byte.
- ack_bit_o  out  1  ACK(0)/NACK(1) the master sends after a read byte.
- data_req_o  out  1  1-cycle pulse: host must present the next TX byte.
- rx_valid_o  out  1  1-cycle pulse: data path data_o holds a complete RX byte.
- busy_o, done_o, nack_o  out  1  busy level; done 1-cycle pulse; nack sticky until next enable_i.

Behaviour:
- Reset: state IDLE; scl_o=1; all strobes, counters, ack_bit_o, pulses, busy_o, nack_o = 0; addr_rw_o=0.
- States: IDLE, START, WRITE_ADDR, READ_ACK, WRITE_DATA, READ_DATA, WRITE_ACK, STOP, REPEAT_START. Exactly one strobe is high per non-IDLE state.
- Edge counter: in bit states, counts 0..2p−1 and wraps (p = prescaler_i). scl_o = 0 for counts p−2..2p−2, else 1. The data path drives SDA at count p−2 and samples at 2p−1.
- IDLE: on enable_i=1, latch addr_rw_i, byte_count_i, repeat_start_i; clear nack_o; set busy_o; go to START.
- START: scl_o=1 and start_cnt_o=1 for p cycles, then go to WRITE_ADDR with the counter at 0.
- WRITE_ADDR: at count 2p−1 with counter_data_ack_i==2, go to READ_ACK.
- READ_ACK: sample sda_i at count 2p−1.
  - sda_i=1: set nack_o, go to STOP.
  - Else if remaining==0: go to STOP, or to REPEAT_START if repeat latched.
  - Else go to WRITE_DATA (R/W=0) or READ_DATA (R/W=1).
- Remaining-byte counter:
  - After a write, it decrements in the READ_ACK that follows each data byte.
  - After a read, it decrements on leaving WRITE_ACK.
- data_req_o pulses on each entry to WRITE_DATA.
- WRITE_DATA and READ_DATA: at count 2p−1 with counter_data_ack_i==2, go to READ_ACK (write) or WRITE_ACK (read).
- Entry to WRITE_ACK: pulse rx_valid_o; ack_bit_o = 1 if remaining==1, else 0.
- WRITE_ACK: at count 2p−1, go to READ_DATA if remaining after decrement is nonzero; else go to STOP or REPEAT_START.
- STOP: one full SCL period with stop_cnt_o=1. Then scl_o=1 for p cycles; then pulse done_o, clear busy_o, go to IDLE.
- REPEAT_START:
  - On entry, load countdown=2p and re-latch addr_rw_i, byte_count_i, repeat_start_i.
  - Countdown decrements each cycle; scl_o=0 while countdown>p, else 1.
  - At countdown 0, go to WRITE_ADDR with the counter at 0; busy_o stays 1 and done_o does not pulse.
- Boundary rules:
  - enable_i is ignored while busy_o=1.
  - prescaler_i is sampled at enable_i and held for the transaction.
  - byte_count_i=0 goes straight from the address ACK to STOP/Sr.
  - A NACK at any READ_ACK aborts to STOP, even when repeat is latched.
  - Reset mid-transfer returns to IDLE immediately with the reset values above.

Test Plan:
- p=4, addr_rw=0xA0, count=1, slave ACKs, TX 0x55 → SCL period 8 cycles; strobes START→WRITE_ADDR→READ_ACK→WRITE_DATA→READ_ACK→STOP; data_req_o pulses once; done_o pulses once; nack_o=0.
- p=4, addr_rw=0xA1, count=2 → two READ_DATA phases; rx_valid_o pulses twice; ack_bit_o 0 then 1; ends in STOP.
- addr_rw=0x42, slave holds sda_i=1 at address ACK → nack_o=1, no WRITE_DATA, STOP then done_o; nack_o clears on the next enable_i.
- count=0, repeat_start=1, then host presents 0x43/count=1 → REPEAT_START countdown 8..0; scl_o high at countdown ≤4; second address phase shows addr_rw_o=0x43; single done_o at the end.
- Assert reset_bit_i during READ_DATA → same cycle: scl_o=1, all strobes 0, busy_o=0; a fresh enable_i starts a normal transaction.
- enable_i pulsed while busy_o=1 → ignored; latched address and count unchanged.
